// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding mux
// selects, sequencing FSM states and the default drain length.
package hazard_pkg;

    // ALU operand mux selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Default number of bubble cycles before halt is acknowledged (1..15)
    localparam int DRAIN_CYCLES_DEF = 3;

    // Drain counter width, wide enough for the largest legal drain length
    localparam int DCNT_W = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU operand: MEM result beats WB result,
// register 0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_reg,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);

    // Priority compare: youngest producer (MEM) wins
    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_reg))
            sel = FWD_MEM;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_reg))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: EX-stage forwarding, load-use stall,
// taken-branch flush and halt/drain handshake.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              halt_req,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halt_ack
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    hz_state_e         state_q;
    logic [DCNT_W-1:0] drain_cnt_q;
    logic              halt_ack_q;
    logic [1:0]        fa_raw, fb_raw;
    logic              load_use;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_reg(ex_rs), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fa_raw)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_reg(ex_rt), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fb_raw)
    );

    // Selects are held at regfile while reset is asserted
    assign forward_a = rst_n ? fa_raw : FWD_REG;
    assign forward_b = rst_n ? fb_raw : FWD_REG;

    assign load_use = ex_memread && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign halt_ack = halt_ack_q;

    // Pipeline register enables/flushes from current state and hazards
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state_q == ST_RUN) begin
            // A taken branch makes the ID instruction wrong-path, so its
            // load-use hazard is irrelevant and no stall is applied.
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end else begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            ifid_flush = ex_branch_taken;
        end
    end

    // Halt/drain sequencing FSM with registered acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            halt_ack_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!halt_req) begin
                        state_q     <= ST_RUN;
                        drain_cnt_q <= '0;
                    end else if (drain_cnt_q == DRAIN_LAST) begin
                        state_q     <= ST_HALTED;
                        drain_cnt_q <= '0;
                        halt_ack_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!halt_req) begin
                        state_q    <= ST_RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    drain_cnt_q <= '0;
                    halt_ack_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_ev, flush_ev;

    // A stall only happens in RUN when no branch overrides it; a branch
    // flushes IF/ID in every state.
    assign stall_ev  = (state_q == ST_RUN) && load_use && !ex_branch_taken;
    assign flush_ev  = ex_branch_taken;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_ev && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_ev && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (DRAIN_CYCLES=3).
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
    logic          id_uses_rt, ex_memread, ex_branch_taken;
    logic          mem_regwrite, wb_regwrite, halt_req;
    logic [1:0]    forward_a, forward_b;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, halt_ack;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(AW), .DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .halt_req(halt_req),
        .forward_a(forward_a), .forward_b(forward_b),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halt_ack(halt_ack)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_rs = '0; id_rt = '0; id_uses_rt = 0;
        ex_rs = '0; ex_rt = '0; ex_memread = 0; ex_branch_taken = 0;
        mem_rd = '0; mem_regwrite = 0; wb_rd = '0; wb_regwrite = 0;
    endtask

    initial begin
        clr_in();
        halt_req = 0;
        rst_n    = 0;
        // Forwarding inputs active during reset must not leak out
        mem_regwrite = 1; mem_rd = 8; ex_rs = 8;
        #3;
        chk("rst_pc_write",   32'(pc_write),   0);
        chk("rst_ifid_write", 32'(ifid_write), 0);
        chk("rst_ifid_flush", 32'(ifid_flush), 1);
        chk("rst_idex_flush", 32'(idex_flush), 1);
        chk("rst_fwd_a",      32'(forward_a),  0);
        chk("rst_halt_ack",   32'(halt_ack),   0);
        #4 rst_n = 1;
        step();
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_stall_rst", stall_cnt, 0);
        chk("cnt_flush_rst", flush_cnt, 0);
`endif

        // Forwarding priority and register-0 exclusion
        wb_regwrite = 1; wb_rd = 8; ex_rt = 8; #1;
        chk("fwd_a_mem",  32'(forward_a), 32'b10);
        chk("fwd_b_mem",  32'(forward_b), 32'b10);
        chk("run_pc",     32'(pc_write),  1);
        chk("run_ifid_w", 32'(ifid_write), 1);
        mem_rd = 0; #1;
        chk("fwd_a_wb",   32'(forward_a), 32'b01);
        ex_rs = 0; wb_rd = 0; #1;
        chk("fwd_a_r0",   32'(forward_a), 32'b00);
        mem_rd = 5; ex_rs = 5; ex_rt = 6; wb_rd = 6; #1;
        chk("fwd_a_mem2", 32'(forward_a), 32'b10);
        chk("fwd_b_wb2",  32'(forward_b), 32'b01);
        clr_in();

        // Load-use stall, then self-clear once the load leaves EX
        step();
        ex_memread = 1; ex_rt = 9; id_rs = 9; #1;
        chk("lu_pc",     32'(pc_write),   0);
        chk("lu_ifid_w", 32'(ifid_write), 0);
        chk("lu_idex_f", 32'(idex_flush), 1);
        chk("lu_ifid_f", 32'(ifid_flush), 0);
        step();
        ex_memread = 0; #1;
        chk("lu_clear_pc", 32'(pc_write), 1);
        chk("lu_clear_idex", 32'(idex_flush), 0);
        step();
        // rt match only counts when ID actually reads rt
        ex_memread = 1; ex_rt = 9; id_rs = 3; id_rt = 9; id_uses_rt = 0; #1;
        chk("lu_no_rt_pc", 32'(pc_write), 1);
        step();
        id_uses_rt = 1; #1;
        chk("lu_rt_pc", 32'(pc_write), 0);
        step();
        ex_rt = 0; id_rs = 0; id_rt = 0; #1;
        chk("lu_r0_pc", 32'(pc_write), 1);

        // Branch overrides load-use
        ex_rt = 9; id_rs = 9; ex_branch_taken = 1; #1;
        chk("br_pc",     32'(pc_write),   1);
        chk("br_ifid_f", 32'(ifid_flush), 1);
        chk("br_idex_f", 32'(idex_flush), 1);
        step();
        clr_in();
`ifdef HAZARD_PERF_CNT_EN
        // Two stalls (id_rs match, id_rt match) and one branch so far
        chk("cnt_stall", stall_cnt, 2);
        chk("cnt_flush", flush_cnt, 1);
`endif

        // Full halt: three drain cycles, then acknowledge
        halt_req = 1; #1;
        chk("halt_req_run_pc", 32'(pc_write), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("drain%0d_pc", k),  32'(pc_write),   0);
            chk($sformatf("drain%0d_ack", k), 32'(halt_ack),   0);
            chk($sformatf("drain%0d_idex", k), 32'(idex_flush), 1);
        end
        step();
        chk("halted_ack", 32'(halt_ack), 1);
        chk("halted_pc",  32'(pc_write), 0);
        ex_branch_taken = 1; #1;
        chk("halted_br_ifid_f", 32'(ifid_flush), 1);
        chk("halted_br_pc",     32'(pc_write),   0);
        ex_branch_taken = 0;
        halt_req = 0; #1;
        chk("unhalt_same_ack", 32'(halt_ack), 1);
        chk("unhalt_same_pc",  32'(pc_write), 0);
        step();
        chk("resume_ack", 32'(halt_ack), 0);
        chk("resume_pc",  32'(pc_write), 1);

        // Short pulse aborts the drain
        halt_req = 1;
        step();
        chk("abort_d0_pc", 32'(pc_write), 0);
        step();
        halt_req = 0;
        step();
        chk("abort_pc",  32'(pc_write), 1);
        chk("abort_ack", 32'(halt_ack), 0);
        step();
        step();
        chk("abort_ack_later", 32'(halt_ack), 0);

        // Reset while halted
        halt_req = 1;
        repeat (4) step();
        chk("pre_rst_ack", 32'(halt_ack), 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_ack",    32'(halt_ack),   0);
        chk("async_rst_ifid_f", 32'(ifid_flush), 1);
        chk("async_rst_idex_f", 32'(idex_flush), 1);
        chk("async_rst_pc",     32'(pc_write),   0);
        halt_req = 0;
        step();
        rst_n = 1;
        step();
        chk("post_rst_pc",  32'(pc_write), 1);
        chk("post_rst_ack", 32'(halt_ack), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_stall_post_rst", stall_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the pipelined datapath: computes EX-stage operand forwarding, load-use stalls and taken-branch flushes.
- Runs a halt/drain handshake that empties the pipeline on request.
- Sits beside the ID/EX/MEM/WB pipeline registers and drives their write-enable and flush inputs plus the ALU operand mux selects.

Parameters:
- REG_AW, 5, register-address width.
- DRAIN_CYCLES, 3, bubble cycles injected before halt is acknowledged; legal 1..15.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  REG_AW  rs of instruction in ID
- id_rt  in  REG_AW  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, BEQ/BNE, store)
- ex_rs  in  REG_AW  rs of instruction in EX
- ex_rt  in  REG_AW  rt of instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX (BEQ/BNE/BGEZ)
- mem_rd  in  REG_AW  destination register in MEM
- mem_regwrite  in  1  MEM instruction writes a register
- wb_rd  in  REG_AW  destination register in WB
- wb_regwrite  in  1  WB instruction writes a register
- halt_req  in  1  level request to halt
- forward_a  out  2  ALU operand A select: 00 regfile, 10 MEM, 01 WB
- forward_b  out  2  ALU operand B select, same encoding
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_flush  out  1  clear ID/EX controls (bubble)
- halt_ack  out  1  pipeline drained and frozen (registered)

Behaviour:
- Reset (rst_n low, async):
  - state=RUN, drain_cnt=0, halt_ack=0.
  - While reset is asserted, force pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, forward_a=forward_b=00.
- Forwarding (combinational, zero latency):
  - forward_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs.
  - Else forward_a=01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs.
  - Else 00.
  - forward_b is identical using ex_rt. MEM has priority over WB when both match.
- load_use = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- FSM states RUN, DRAIN, HALTED.
- RUN:
  - Defaults: pc_write=1, ifid_write=1, flushes=0.
  - ex_branch_taken=1: ifid_flush=1, idex_flush=1, pc_write=1. Branch beats load_use because the ID instruction is wrong-path, so no stall is applied.
  - Else load_use=1: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble per occurrence; it self-clears next cycle because the bubble clears ex_memread.
  - halt_req=1: go to DRAIN next edge with drain_cnt=0. The current cycle's outputs still follow the RUN rules.
- DRAIN:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1. ifid_flush additionally =1 if ex_branch_taken.
  - drain_cnt increments each cycle.
  - When drain_cnt==DRAIN_CYCLES-1: go to HALTED and set halt_ack=1 on the same edge.
  - halt_req dropping during DRAIN aborts to RUN next edge; drain_cnt cleared, halt_ack stays 0.
- HALTED:
  - Outputs same as DRAIN; halt_ack=1.
  - halt_req=0: go to RUN, halt_ack=0 on the same edge. Normal fetch resumes the following cycle.
- Forwarding stays active in all states.
- Reset asserted mid-DRAIN or in HALTED returns immediately to RUN, halt_ack=0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: extra outputs stall_cnt[CNT_W] and flush_cnt[CNT_W].
  - stall_cnt increments on each RUN cycle with a load-use stall.
  - flush_cnt increments on each cycle with ifid_flush=1 caused by ex_branch_taken.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; all other behaviour unchanged.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - State encoding RUN/DRAIN/HALTED.
  - Default DRAIN_CYCLES.
- One natural sub-module, fwd_sel: the compare/priority logic for one operand, instantiated twice (A with ex_rs, B with ex_rt).

Test Plan:
- mem_regwrite=1, mem_rd=8, wb_regwrite=1, wb_rd=8, ex_rs=8 -> forward_a=10; then mem_rd=0 -> forward_a=01; ex_rs=0 with wb_rd=0 -> forward_a=00.
- ex_memread=1, ex_rt=9, id_rs=9 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle with ex_memread=0 -> pc_write=1. With id_rt=9, id_uses_rt=0, id_rs=3 -> no stall.
- Load-use and ex_branch_taken in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1.
- halt_req held high with DRAIN_CYCLES=3 -> pc_write=0 for 3 cycles, then halt_ack=1 on the 3rd edge; drop halt_req -> halt_ack=0 and pc_write=1 one cycle later.
- halt_req pulsed for 2 cycles -> DRAIN aborts, halt_ack never rises, RUN resumes.
- rst_n asserted while HALTED -> halt_ack=0 asynchronously, flushes=1; after release -> RUN. With HAZARD_PERF_CNT_EN, 2 stalls and 1 flush -> stall_cnt=2, flush_cnt=1.
